// File: rtl/mem_io_arbiter.sv
// Data-bus arbiter/sequencer: shares the data BRAM and LED/switch registers
// between the CPU port and a debug/loader port. Define DBG_PORT_EN for dual-port round-robin.
module mem_io_arbiter #(
  parameter logic [31:0] LED_ADDR = 32'hFFFF_FC60,
  parameter logic [31:0] SW_ADDR  = 32'hFFFF_FC70,
  parameter logic [21:0] IO_TAG   = 22'h3F_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic [15:0] sw,
  output logic [15:0] led_out
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_dbg_q, last_dbg_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] led_q, led_d;
  logic [15:0] sw_cap_q, sw_cap_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic        dbg_ready_q, dbg_ready_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;

  logic        sel_dbg, req_any;
  logic        req_we, req_io;
  logic [31:0] req_addr, req_wdata;
  logic        is_io, is_led, is_sw;
  logic [31:0] resp_data;

`ifdef DBG_PORT_EN
  // On a tie the port not granted last wins.
  assign sel_dbg   = dbg_req & (~cpu_req | ~last_dbg_q);
  assign req_any   = cpu_req | dbg_req;
  assign dbg_ready = dbg_ready_q;
  assign dbg_rdata = dbg_ready_q ? resp_data : dbg_rdata_q;
`else
  assign sel_dbg   = 1'b0;
  assign req_any   = cpu_req;
  assign dbg_ready = 1'b0;
  assign dbg_rdata = '0;
  logic unused_dbg;
  assign unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata,
                        dbg_ready_q, dbg_rdata_q, last_dbg_q};
`endif

  assign req_we    = sel_dbg ? dbg_we    : cpu_we;
  assign req_addr  = sel_dbg ? dbg_addr  : cpu_addr;
  assign req_wdata = sel_dbg ? dbg_wdata : cpu_wdata;
  assign req_io    = (req_addr[31:10] == IO_TAG);

  assign is_io  = (addr_q[31:10] == IO_TAG);
  assign is_led = is_io && ({addr_q[31:2], 2'b00} == LED_ADDR);
  assign is_sw  = is_io && ({addr_q[31:2], 2'b00} == SW_ADDR);

  always_comb begin
    resp_data = '0;
    if (!we_q) begin
      if (!is_io)      resp_data = mem_rdata;
      else if (is_led) resp_data = {16'b0, led_q};
      else if (is_sw)  resp_data = {16'b0, sw_cap_q};
    end
  end

  // Memory address/enable are loaded on accept so they are registered while in ACCESS.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_dbg_d  = last_dbg_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    led_d       = led_q;
    sw_cap_d    = sw_cap_q;
    cpu_ready_d = 1'b0;
    dbg_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_d    = S_ACCESS;
          grant_d    = sel_dbg;
          last_dbg_d = sel_dbg;
          we_d       = req_we;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          if (!req_io) begin
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
            mem_we_d    = req_we;
          end
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (we_q && is_led) led_d = wdata_q[15:0];
        if (!we_q && is_sw) sw_cap_d = sw;
        cpu_ready_d = ~grant_q;
        dbg_ready_d = grant_q;
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (grant_q) dbg_rdata_d = resp_data;
        else         cpu_rdata_d = resp_data;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      last_dbg_q  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      led_q       <= '0;
      sw_cap_q    <= '0;
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_dbg_q  <= last_dbg_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      led_q       <= led_d;
      sw_cap_q    <= sw_cap_d;
      cpu_ready_q <= cpu_ready_d;
      dbg_ready_q <= dbg_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign led_out   = led_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_ready_q ? resp_data : cpu_rdata_q;

endmodule
